// File: rtl/post_code_pkg.sv
`default_nettype none
// ============================================================================
// Module   : post_code_pkg
// Purpose  : Shared types and constants for the POST-code sequencer.
//            Holds the frame FSM state encoding, the port-ID constants, the
//            header sync bit, the FIFO entry type and a header-builder helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package post_code_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DHI  = 3'd2,
      ST_DLO  = 3'd3,
      ST_CHK  = 3'd4
   } seq_state_t;

   localparam logic PORT_80  = 1'b0;
   localparam logic PORT_81  = 1'b1;
   localparam logic HDR_SYNC = 1'b1;

   typedef struct packed {
      logic       port_id;
      logic [7:0] data;
   } post_entry_t;

   // Header nibble: {sync, overflow snapshot, reserved 0, port id}
   function automatic logic [3:0] mk_hdr(input logic ovf, input logic pid);
      return {HDR_SYNC, ovf, 1'b0, pid};
   endfunction

endpackage
`default_nettype wire

// File: rtl/post_code_fifo.sv
`default_nettype none
// ============================================================================
// Module   : post_code_fifo
// Purpose  : Synchronous FIFO of POST entries. Pointers carry one extra bit so
//            full and empty are distinguished by the occupancy difference.
//            Simultaneous push and pop are legal in any state, including full.
// Ports    : sys_clk, rst_n      - clock, async active-low reset
//            push, push_data     - write request and entry
//            pop, pop_data       - read request; pop_data is the current head
//            full, empty, level  - status
// Revision : 1.0 - initial release
// ============================================================================
module post_code_fifo
   import post_code_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     sys_clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  post_entry_t              push_data,
   input  logic                     pop,
   output post_entry_t              pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int              c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

   post_entry_t     r_mem [DEPTH];
   logic [c_AW:0]   r_wr_ptr;
   logic [c_AW:0]   r_rd_ptr;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; only locations behind the write pointer are read.
   always_ff @(posedge sys_clk) begin
      if (push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
   end

   assign pop_data = r_mem[r_rd_ptr[c_AW-1:0]];
   assign level    = r_wr_ptr - r_rd_ptr;
   assign full     = (level == c_FULL);
   assign empty    = (level == '0);

endmodule
`default_nettype wire

// File: rtl/post_code_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : post_code_sequencer
// Purpose  : Stages port 80h/81h POST-code writes, arbitrates them round-robin
//            into a FIFO and serialises each entry as a 4-nibble frame
//            (header, data hi, data lo, checksum) on a 4-bit QSPI output.
// Ports    : sys_clk, rst_n            - clock, async active-low reset
//            p80_wr/p80_data           - port 80h write strobe and data
//            p81_wr/p81_data           - port 81h write strobe and data
//            qspi_ack                  - host consumed current nibble
//            ovf_clr                   - clear sticky overflow
//            qspi_out/qspi_valid       - frame nibble and its qualifier
//            qspi_int                  - data pending
//            overflow                  - sticky drop flag
//            fifo_level                - FIFO occupancy
// Config   : POST_DEDUP_EN - drop writes equal to the last value pushed for
//            the same port (last-value registers reset to 0x00).
// Revision : 1.0 - initial release
// ============================================================================
module post_code_sequencer
   import post_code_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          sys_clk,
   input  logic                          rst_n,
   input  logic                          p80_wr,
   input  logic [7:0]                    p80_data,
   input  logic                          p81_wr,
   input  logic [7:0]                    p81_data,
   input  logic                          qspi_ack,
   input  logic                          ovf_clr,
   output logic [3:0]                    qspi_out,
   output logic                          qspi_valid,
   output logic                          qspi_int,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   logic          r_stg80_vld, r_stg81_vld;
   logic [7:0]    r_stg80_data, r_stg81_data;
   logic          r_rr_ptr;
   seq_state_t    r_state;
   post_entry_t   r_cur;
   logic [3:0]    r_hdr;

   logic          w_take80, w_take81;
   logic          w_full, w_empty, w_pop, w_push, w_sel81;
   logic          w_drain80, w_drain81, w_ovf_set;
   post_entry_t   w_push_entry, w_head;
   logic [3:0]    w_hdr_new;

`ifdef POST_DEDUP_EN
   logic [7:0]    r_last80, r_last81;

   assign w_take80 = p80_wr && (p80_data != r_last80);
   assign w_take81 = p81_wr && (p81_data != r_last81);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last80 <= 8'h00;
         r_last81 <= 8'h00;
      end else begin
         if (w_drain80) r_last80 <= r_stg80_data;
         if (w_drain81) r_last81 <= r_stg81_data;
      end
   end
`else
   assign w_take80 = p80_wr;
   assign w_take81 = p81_wr;
`endif

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign w_pop        = !w_empty && ((r_state == ST_IDLE) ||
                                      (r_state == ST_CHK && qspi_ack));
   assign w_sel81      = r_stg81_vld && (!r_stg80_vld || r_rr_ptr);
   assign w_push       = (r_stg80_vld || r_stg81_vld) && (!w_full || w_pop);
   assign w_push_entry = w_sel81 ? '{port_id: PORT_81, data: r_stg81_data}
                                 : '{port_id: PORT_80, data: r_stg80_data};
   assign w_drain80    = w_push && !w_sel81;
   assign w_drain81    = w_push &&  w_sel81;

   // Only a code that is actually lost counts; a register that drains in the
   // same cycle it is rewritten has already handed its old entry to the FIFO.
   assign w_ovf_set    = (w_take80 && r_stg80_vld && !w_drain80) ||
                         (w_take81 && r_stg81_vld && !w_drain81);

   assign w_hdr_new    = mk_hdr(overflow, w_head.port_id);
   assign qspi_int     = (fifo_level != '0) || (r_state != ST_IDLE);

   post_code_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_entry),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fifo_level)
   );

   // Staging, arbiter pointer and overflow flag
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stg80_vld  <= 1'b0;
         r_stg81_vld  <= 1'b0;
         r_stg80_data <= 8'h00;
         r_stg81_data <= 8'h00;
         r_rr_ptr     <= PORT_80;
         overflow     <= 1'b0;
      end else begin
         if (w_take80) begin
            r_stg80_vld  <= 1'b1;
            r_stg80_data <= p80_data;
         end else if (w_drain80) begin
            r_stg80_vld  <= 1'b0;
         end
         if (w_take81) begin
            r_stg81_vld  <= 1'b1;
            r_stg81_data <= p81_data;
         end else if (w_drain81) begin
            r_stg81_vld  <= 1'b0;
         end
         if (w_push && r_stg80_vld && r_stg81_vld) r_rr_ptr <= ~r_rr_ptr;
         if (w_ovf_set)    overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // Frame sequencer
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cur      <= '0;
         r_hdr      <= 4'h0;
         qspi_out   <= 4'h0;
         qspi_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_cur      <= w_head;
                  r_hdr      <= w_hdr_new;
                  qspi_out   <= w_hdr_new;
                  qspi_valid <= 1'b1;
                  r_state    <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (qspi_ack) begin
                  qspi_out <= r_cur.data[7:4];
                  r_state  <= ST_DHI;
               end
            end
            ST_DHI: begin
               if (qspi_ack) begin
                  qspi_out <= r_cur.data[3:0];
                  r_state  <= ST_DLO;
               end
            end
            ST_DLO: begin
               if (qspi_ack) begin
                  qspi_out <= r_hdr ^ r_cur.data[7:4] ^ r_cur.data[3:0];
                  r_state  <= ST_CHK;
               end
            end
            ST_CHK: begin
               if (qspi_ack) begin
                  if (w_pop) begin
                     r_cur    <= w_head;
                     r_hdr    <= w_hdr_new;
                     qspi_out <= w_hdr_new;
                     r_state  <= ST_HDR;
                  end else begin
                     qspi_out   <= 4'h0;
                     qspi_valid <= 1'b0;
                     r_state    <= ST_IDLE;
                  end
               end
            end
            default: begin
               qspi_out   <= 4'h0;
               qspi_valid <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_post_code_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_post_code_sequencer
// Purpose  : Directed self-checking bench for post_code_sequencer with
//            hand-computed frame values (header,hi,lo,chk packed as 16 bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_post_code_sequencer;

   logic       sys_clk = 1'b0;
   logic       rst_n   = 1'b0;
   logic       p80_wr  = 1'b0;
   logic [7:0] p80_data = 8'h00;
   logic       p81_wr  = 1'b0;
   logic [7:0] p81_data = 8'h00;
   logic       qspi_ack = 1'b0;
   logic       ovf_clr  = 1'b0;
   logic [3:0] qspi_out;
   logic       qspi_valid;
   logic       qspi_int;
   logic       overflow;
   logic [3:0] fifo_level;

   int total = 0;
   int bad   = 0;

   always #5 sys_clk = ~sys_clk;

   post_code_sequencer #(.FIFO_DEPTH(8)) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .p80_wr     (p80_wr),
      .p80_data   (p80_data),
      .p81_wr     (p81_wr),
      .p81_data   (p81_data),
      .qspi_ack   (qspi_ack),
      .ovf_clr    (ovf_clr),
      .qspi_out   (qspi_out),
      .qspi_valid (qspi_valid),
      .qspi_int   (qspi_int),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wr80(input logic [7:0] d);
      p80_data = d; p80_wr = 1'b1;
      tick;
      p80_wr = 1'b0;
      tick;
   endtask

   task automatic wr81(input logic [7:0] d);
      p81_data = d; p81_wr = 1'b1;
      tick;
      p81_wr = 1'b0;
      tick;
   endtask

   // Waits (bounded) for a frame, acks all four nibbles back-to-back and
   // compares {all_valid, frame}.
   task automatic recv_frame(input string tag, input logic [15:0] exp);
      int          n;
      logic [15:0] f;
      logic        vall;
      n = 0;
      while (!qspi_valid && n < 50) begin
         tick;
         n++;
      end
      f = 16'h0;
      vall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         f = {f[11:0], qspi_out};
         vall = vall & qspi_valid;
         qspi_ack = 1'b1;
         tick;
      end
      qspi_ack = 1'b0;
      chk_eq(tag, {15'd0, vall, f}, {15'd0, 1'b1, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_nib [8];
      logic [3:0] lo;

      // ---------------- reset ----------------
      tick; tick;
      chk_eq("reset_outs", {qspi_out, 3'b0, qspi_valid, 3'b0, qspi_int, 3'b0, overflow, fifo_level},
             32'h0);
      rst_n = 1'b1;
      tick;

      // ---------------- single frame, latency ----------------
      p80_data = 8'h3C; p80_wr = 1'b1;
      tick;
      p80_wr = 1'b0;
      chk_eq("t1_lvl_n1", 32'(fifo_level), 32'd0);
      tick;
      chk_eq("t1_lvl_n2", {27'd0, qspi_valid, fifo_level}, {27'd0, 1'b0, 4'd1});
      tick;
      chk_eq("t1_hdr", {27'd0, qspi_valid, qspi_out}, {27'd0, 1'b1, 4'h8});
      qspi_ack = 1'b1;
      tick; chk_eq("t1_dhi", 32'(qspi_out), 32'h3);
      tick; chk_eq("t1_dlo", 32'(qspi_out), 32'hC);
      tick; chk_eq("t1_chk", 32'(qspi_out), 32'h7);
      tick;
      qspi_ack = 1'b0;
      chk_eq("t1_int_drop", {qspi_int, qspi_valid}, 32'd0);

      // ---------------- simultaneous writes, round robin ----------------
      p80_data = 8'hA5; p81_data = 8'h5A; p80_wr = 1'b1; p81_wr = 1'b1;
      tick;
      p80_wr = 1'b0; p81_wr = 1'b0;
      recv_frame("rr1_first", 16'h8A57);
      recv_frame("rr1_second", 16'h95A6);
      p80_data = 8'h01; p81_data = 8'h02; p80_wr = 1'b1; p81_wr = 1'b1;
      tick;
      p80_wr = 1'b0; p81_wr = 1'b0;
      recv_frame("rr2_first", 16'h902B);
      recv_frame("rr2_second", 16'h8019);
      tick;

      // ---------------- fill, back-pressure, overflow ----------------
      for (int i = 0; i < 9; i++) wr80(8'h10 + 8'(i));
      tick; tick;
      chk_eq("fill_level", 32'(fifo_level), 32'd8);
      wr80(8'h20);
      chk_eq("bp_hold", {27'd0, overflow, fifo_level}, {27'd0, 1'b0, 4'd8});
      wr80(8'h21);
      chk_eq("ovf_set", 32'(overflow), 32'd1);
      wr81(8'h30);
      chk_eq("ovf_cur_hdr", {27'd0, qspi_valid, qspi_out}, {27'd0, 1'b1, 4'h8});
      recv_frame("ovf_f10", 16'h8109);
      chk_eq("ovf_snap_hdr", 32'(qspi_out), 32'hC);
      ovf_clr = 1'b1;
      tick;
      ovf_clr = 1'b0;
      chk_eq("ovf_clr", 32'(overflow), 32'd0);
      recv_frame("ovf_f11", 16'hC11C);
      recv_frame("ovf_f12", 16'h812B);
      for (int i = 3; i < 9; i++) begin
         lo = 4'(i);
         recv_frame("drain_f1x", {8'h81, lo, 4'h9 ^ lo});
      end
      recv_frame("drain_f21", 16'h821B);
      recv_frame("drain_f30", 16'h930A);
      tick;
      chk_eq("drain_idle", {27'd0, qspi_int, fifo_level}, 32'd0);

      // ---------------- back-to-back frames, ack held ----------------
      wr80(8'h3C);
      wr80(8'h5A);
      tick; tick;
      chk_eq("b2b_pre", {23'd0, qspi_valid, qspi_out, fifo_level}, {23'd0, 1'b1, 4'h8, 4'd1});
      exp_nib = '{4'h8, 4'h3, 4'hC, 4'h7, 4'h8, 4'h5, 4'hA, 4'h7};
      qspi_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk_eq("b2b_nib", {27'd0, qspi_valid, qspi_out}, {27'd0, 1'b1, exp_nib[i]});
         if (i == 0) chk_eq("b2b_lvl0", 32'(fifo_level), 32'd1);
         if (i == 4) chk_eq("b2b_lvl4", 32'(fifo_level), 32'd0);
         tick;
      end
      qspi_ack = 1'b0;
      chk_eq("b2b_end", {qspi_valid, qspi_int}, 32'd0);

      // ---------------- reset during DLO ----------------
      wr80(8'h3C);
      wr81(8'h77);
      qspi_ack = 1'b1;
      tick; tick;
      qspi_ack = 1'b0;
      chk_eq("rst_in_dlo", {27'd0, qspi_valid, qspi_out}, {27'd0, 1'b1, 4'hC});
      rst_n = 1'b0;
      #1;
      chk_eq("rst_async", {qspi_out, 3'b0, qspi_valid, 3'b0, qspi_int, 3'b0, overflow, fifo_level},
             32'h0);
      tick;
      rst_n = 1'b1;
      tick;
      wr80(8'h96);
      recv_frame("rst_new", 16'h8967);
      tick;
      chk_eq("rst_noreplay", 32'(qspi_int), 32'd0);

      // ---------------- duplicate writes ----------------
      wr80(8'h11);
      tick; tick; tick;
      wr80(8'h11);
      recv_frame("dup_first", 16'h8118);
`ifdef POST_DEDUP_EN
      tick; tick; tick;
      chk_eq("dup_dropped", 32'(qspi_int), 32'd0);
`else
      recv_frame("dup_second", 16'h8118);
      tick;
      chk_eq("dup_done", 32'(qspi_int), 32'd0);
`endif
      chk_eq("dup_no_ovf", 32'(overflow), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
